led_pwm_scan_out: RTL

- Downstream neighbour of the GCK-domain read/output controller in the LED display controller.
- Fetches one scan line of grey values (CH channels × GW bits) from frame SRAM, drives CH PWM outputs for 2^GW GCK cycles per scan line, and advances the scan line.
- Prefetches the next line while the current one is displayed (double buffer).
- Pulses frameout_done after the last scan line; the controller uses this pulse to leave its read/output state.

---
 rtl/led_pwm_scan_out.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/led_pwm_scan_out.sv
// led_pwm_scan_out: fetches one scan line of grey values from frame SRAM,
// drives CH PWM outputs for one 2^GW-cycle period per line and prefetches
// the following line while the current one is being displayed.
module led_pwm_scan_out #(
  parameter int CH     = 16,
  parameter int GW     = 8,
  parameter int SCANS  = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic               GCK,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               out_en,
  input  logic [CH*GW-1:0]   mem_q,
  output logic               mem_cen_n,
  output logic [AW-1:0]      mem_addr,
  output logic [CH-1:0]      OUT,
  output logic [AW-1:0]      scan_sel,
  output logic               busy,
  output logic               frameout_done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    RUN
  } state_t;

  localparam int FW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [AW-1:0] LAST_SCAN  = AW'(SCANS - 1);
  localparam logic [GW-1:0] CNT_MAX    = '1;
  localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LAT);

  state_t           state;
  state_t           state_nxt;
  logic [FW-1:0]    fetch_cnt;
  logic [GW-1:0]    gck_cnt;
  logic [AW-1:0]    scan;
  logic [CH*GW-1:0] cur_buf;
  logic [CH*GW-1:0] next_buf;
  logic [RD_LAT-1:0] pf_pend;

  logic fetch_strobe;
  logic fetch_capture;
  logic pf_strobe;
  logic pf_capture;
  logic period_end;
  logic frame_end;

  // Decode the read strobes, captures and period/frame boundaries for this cycle.
  always_comb begin
    fetch_strobe  = 1'b0;
    fetch_capture = 1'b0;
    pf_strobe     = 1'b0;
    period_end    = 1'b0;
    frame_end     = 1'b0;
    pf_capture    = pf_pend[RD_LAT-1];
    if (state == FETCH0) begin
      fetch_strobe  = (fetch_cnt == '0);
      fetch_capture = (fetch_cnt == FETCH_LAST);
    end
    if (state == RUN) begin
      pf_strobe  = out_en && (gck_cnt == '0) && (scan != LAST_SCAN);
      period_end = out_en && (gck_cnt == CNT_MAX);
      frame_end  = period_end && (scan == LAST_SCAN);
    end
  end

  // State register.
  always_ff @(posedge GCK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the combinational control outputs.
  always_comb begin
    state_nxt     = state;
    mem_cen_n     = 1'b1;
    mem_addr      = '0;
    busy          = (state != IDLE);
    frameout_done = frame_end;
    scan_sel      = scan;
    if (fetch_strobe || pf_strobe) mem_cen_n = 1'b0;
    if (pf_strobe) mem_addr = scan + AW'(1);
    case (state)
      IDLE:    if (frame_start) state_nxt = FETCH0;
      FETCH0:  if (fetch_capture) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: fetch counter, PWM counter, line buffers, scan index and PWM outputs.
  always_ff @(posedge GCK or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      gck_cnt   <= '0;
      scan      <= '0;
      cur_buf   <= '0;
      next_buf  <= '0;
      pf_pend   <= '0;
      OUT       <= '0;
    end else begin
      pf_pend[0] <= pf_strobe;
      for (int k = 1; k < RD_LAT; k++) pf_pend[k] <= pf_pend[k-1];
      case (state)
        IDLE: begin
          OUT       <= '0;
          fetch_cnt <= '0;
          if (frame_start) begin
            scan    <= '0;
            gck_cnt <= '0;
          end
        end
        FETCH0: begin
          OUT       <= '0;
          fetch_cnt <= fetch_cnt + FW'(1);
          if (fetch_capture) cur_buf <= mem_q;
        end
        RUN: begin
          for (int i = 0; i < CH; i++)
            OUT[i] <= out_en && (gck_cnt < cur_buf[i*GW +: GW]);
          if (pf_capture) next_buf <= mem_q;
          if (out_en) gck_cnt <= gck_cnt + GW'(1);
          if (period_end) begin
            if (scan == LAST_SCAN) begin
              scan <= '0;
            end else begin
              cur_buf <= next_buf;
              scan    <= scan + AW'(1);
            end
          end
        end
        default: OUT <= '0;
      endcase
    end
  end

endmodule
